// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller: instruction types,
// FSM state encoding and the NOP pattern loaded into flushed stage registers.
package hazard_ctrl_pkg;

  localparam logic [1:0] TypeR   = 2'b00;
  localparam logic [1:0] TypeMem = 2'b01;
  localparam logic [1:0] TypeImm = 2'b10;
  localparam logic [1:0] TypeBr  = 2'b11;

  localparam logic [15:0] NopInstr = 16'h0000;

  // Branches compare rs1, so every instruction type reads rs1.
  localparam logic BrReadsRs1 = 1'b1;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StLstall  = 2'b01,
    StFlush   = 2'b10,
    StMemWait = 2'b11
  } state_e;

  function automatic logic rs1_read(input logic [1:0] id_type);
    return (id_type != TypeBr) || BrReadsRs1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: memory freeze, taken-branch squash and
// load-use bubble insertion, with saturating stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        id_type_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs2_used_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_br_taken_i,
  input  logic              mem_req_i,
  input  logic              mem_ready_i,
  output logic              pc_write_o,
  output logic              pc_sel_br_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_write_o,
  output logic              idex_bubble_o,
  output logic              exmem_write_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic              mem_err_o
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax  = WaitW'(MEM_TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             mem_err_q, mem_err_d;

  logic mem_wait, lu_hit, br_act, lu_act;

  always_comb begin
    mem_wait = mem_req_i & ~mem_ready_i;
    lu_hit   = ex_mem_read_i && (ex_rd_i != '0) &&
               (((ex_rd_i == id_rs1_i) && rs1_read(id_type_i)) ||
                (id_rs2_used_i && (ex_rd_i == id_rs2_i)));
    br_act   = ex_br_taken_i & ~mem_wait;
    // After a flush ID holds a NOP; after a bubble the load has left EX.
    lu_act   = lu_hit && ~mem_wait && ~ex_br_taken_i &&
               (state_q != StFlush) && (state_q != StLstall);
  end

  always_comb begin
    pc_write_o    = 1'b1;
    pc_sel_br_o   = 1'b0;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_write_o  = 1'b1;
    idex_bubble_o = 1'b0;
    exmem_write_o = 1'b1;
    if (!rst_ni) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      exmem_write_o = 1'b0;
    end else if (mem_wait) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      exmem_write_o = 1'b0;
    end else if (br_act) begin
      pc_sel_br_o   = 1'b1;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (lu_act) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end
  end

  always_comb begin
    state_d   = StRun;
    wait_d    = '0;
    mem_err_d = mem_err_q;
    if (mem_wait) begin
      state_d = StMemWait;
      wait_d  = (wait_q == WaitMax) ? wait_q : wait_q + 1'b1;
      if (wait_q >= WaitLast) begin
        mem_err_d = 1'b1;
      end
    end else if (br_act) begin
      state_d = StFlush;
    end else if (lu_act) begin
      state_d = StLstall;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StRun;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err_o = mem_err_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (mem_wait | lu_act),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (br_act),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int unsigned RegAw  = 4;
  localparam int unsigned CntW   = 4;
  localparam int unsigned MemTo  = 4;
  localparam int          CntMax = (1 << CntW) - 1;

  localparam logic [6:0] CtrlReset = 7'b0001010;
  localparam logic [6:0] CtrlRun   = 7'b1010101;
  localparam logic [6:0] CtrlFrz   = 7'b0000000;
  localparam logic [6:0] CtrlBr    = 7'b1111111;
  localparam logic [6:0] CtrlLu    = 7'b0000111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       id_type;
  logic [RegAw-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_rs2_used, ex_mem_read, ex_br_taken, mem_req, mem_ready;
  logic             pc_write, pc_sel_br, ifid_write, ifid_flush;
  logic             idex_write, idex_bubble, exmem_write, mem_err;
  logic [CntW-1:0]  stall_cnt, flush_cnt;
  logic [6:0]       obs;

  assign obs = {pc_write, pc_sel_br, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write};

  hazard_ctrl #(
    .REG_AW     (RegAw),
    .CNT_W      (CntW),
    .MEM_TIMEOUT(MemTo)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .id_type_i    (id_type),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_rs2_used_i(id_rs2_used),
    .ex_mem_read_i(ex_mem_read),
    .ex_rd_i      (ex_rd),
    .ex_br_taken_i(ex_br_taken),
    .mem_req_i    (mem_req),
    .mem_ready_i  (mem_ready),
    .pc_write_o   (pc_write),
    .pc_sel_br_o  (pc_sel_br),
    .ifid_write_o (ifid_write),
    .ifid_flush_o (ifid_flush),
    .idex_write_o (idex_write),
    .idex_bubble_o(idex_bubble),
    .exmem_write_o(exmem_write),
    .stall_cnt_o  (stall_cnt),
    .flush_cnt_o  (flush_cnt),
    .mem_err_o    (mem_err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: what happened last cycle, plus plain integer counters.
  bit m_after_br, m_after_lu, m_err;
  int m_wait, m_stall, m_flush;

  function automatic bit m_memwait();
    return mem_req && !mem_ready;
  endfunction

  function automatic bit m_loaduse();
    return ex_mem_read && (ex_rd != 0) &&
           ((ex_rd == id_rs1) || (id_rs2_used && (ex_rd == id_rs2))) &&
           !m_after_br && !m_after_lu;
  endfunction

  function automatic logic [6:0] exp_ctrl();
    if (m_memwait()) return CtrlFrz;
    if (ex_br_taken) return CtrlBr;
    if (m_loaduse()) return CtrlLu;
    return CtrlRun;
  endfunction

  task automatic model_step();
    bit mw, lu;
    mw = m_memwait();
    lu = m_loaduse();
    if (mw) begin
      m_stall = (m_stall < CntMax) ? m_stall + 1 : m_stall;
      m_wait  = m_wait + 1;
      if (m_wait >= MemTo) m_err = 1'b1;
      m_after_br = 1'b0;
      m_after_lu = 1'b0;
    end else begin
      m_wait = 0;
      m_after_br = ex_br_taken;
      m_after_lu = !ex_br_taken && lu;
      if (ex_br_taken) m_flush = (m_flush < CntMax) ? m_flush + 1 : m_flush;
      else if (lu) m_stall = (m_stall < CntMax) ? m_stall + 1 : m_stall;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_type     = 2'b00;
    id_rs1      = '0;
    id_rs2      = '0;
    id_rs2_used = 1'b0;
    ex_mem_read = 1'b0;
    ex_rd       = '0;
    ex_br_taken = 1'b0;
    mem_req     = 1'b0;
    mem_ready   = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    #2 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_after_br = 1'b0;
    m_after_lu = 1'b0;
    m_err      = 1'b0;
    m_wait     = 0;
    m_stall    = 0;
    m_flush    = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #3;
    checks++;
    if (obs !== CtrlReset) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=%b", obs, CtrlReset);
    end
    checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0 || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs got stall=%0d flush=%0d err=%b want 0/0/0",
               stall_cnt, flush_cnt, mem_err);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_req   = 1'b1;
    mem_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (stall_cnt !== 4'd2) begin
      failures++;
      $display("FAIL midwait_pre stall got=%0d want=2", stall_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== CtrlReset || stall_cnt !== '0) begin
      failures++;
      $display("FAIL midwait_reset got ctrl=%b stall=%0d want ctrl=%b stall=0",
               obs, stall_cnt, CtrlReset);
    end
    tick();
    idle();
    rst_n = 1'b1;
    #2;
    checks++;
    if (obs !== CtrlRun) begin
      failures++;
      $display("FAIL midwait_run got=%b want=%b", obs, CtrlRun);
    end
    tick();
    checks++;
    if (stall_cnt !== '0) begin
      failures++;
      $display("FAIL midwait_post stall got=%0d want=0", stall_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1;
    ex_rd       = 4'd3;
    id_rs1      = 4'd3;
    id_rs2      = 4'd7;
    id_rs2_used = 1'b1;
    #2;
    checks++;
    if (obs !== CtrlLu) begin
      failures++;
      $display("FAIL lu_stall got=%b want=%b", obs, CtrlLu);
    end
    tick();
    #2;
    checks++;
    if (obs !== CtrlRun) begin
      failures++;
      $display("FAIL lu_no_double got=%b want=%b", obs, CtrlRun);
    end
    tick();
    checks++;
    if (stall_cnt !== 4'd1) begin
      failures++;
      $display("FAIL lu_count got=%0d want=1", stall_cnt);
    end
    idle();
  endtask

  task automatic test_no_hazard();
    do_reset();
    ex_mem_read = 1'b1;
    ex_rd       = 4'd0;
    id_rs1      = 4'd0;
    #2;
    checks++;
    if (obs !== CtrlRun) begin
      failures++;
      $display("FAIL nohaz_r0 got=%b want=%b", obs, CtrlRun);
    end
    tick();
    ex_rd       = 4'd3;
    id_rs1      = 4'd5;
    id_rs2      = 4'd3;
    id_rs2_used = 1'b0;
    #2;
    checks++;
    if (obs !== CtrlRun) begin
      failures++;
      $display("FAIL nohaz_rs2 got=%b want=%b", obs, CtrlRun);
    end
    tick();
    checks++;
    if (stall_cnt !== '0) begin
      failures++;
      $display("FAIL nohaz_count got=%0d want=0", stall_cnt);
    end
    idle();
  endtask

  task automatic test_branch_wins();
    do_reset();
    ex_mem_read = 1'b1;
    ex_rd       = 4'd3;
    id_rs1      = 4'd3;
    ex_br_taken = 1'b1;
    #2;
    checks++;
    if (obs !== CtrlBr) begin
      failures++;
      $display("FAIL br_ctrl got=%b want=%b", obs, CtrlBr);
    end
    tick();
    idle();
    checks++;
    if (flush_cnt !== 4'd1 || stall_cnt !== '0) begin
      failures++;
      $display("FAIL br_counts got flush=%0d stall=%0d want 1/0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_mem_freeze();
    do_reset();
    mem_req     = 1'b1;
    mem_ready   = 1'b0;
    ex_br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (obs !== CtrlFrz) begin
        failures++;
        $display("FAIL freeze_ctrl cycle=%0d got=%b want=%b", i, obs, CtrlFrz);
      end
      tick();
    end
    mem_ready = 1'b1;
    #2;
    checks++;
    if (obs !== CtrlBr) begin
      failures++;
      $display("FAIL freeze_release got=%b want=%b", obs, CtrlBr);
    end
    tick();
    idle();
    checks++;
    if (stall_cnt !== 4'd3 || flush_cnt !== 4'd1 || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL freeze_counts got stall=%0d flush=%0d err=%b want 3/1/0",
               stall_cnt, flush_cnt, mem_err);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req   = 1'b1;
    mem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (mem_err !== logic'(i >= MemTo)) begin
        failures++;
        $display("FAIL timeout_err wait=%0d got=%b want=%b", i, mem_err, (i >= MemTo));
      end
    end
    mem_ready = 1'b1;
    tick();
    idle();
    tick();
    checks++;
    if (mem_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky got=%b want=1", mem_err);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_req   = 1'b1;
    mem_ready = 1'b0;
    repeat (CntMax + 5) tick();
    idle();
    ex_br_taken = 1'b1;
    repeat (CntMax + 5) tick();
    idle();
    checks++;
    if (stall_cnt !== CntW'(CntMax) || flush_cnt !== CntW'(CntMax)) begin
      failures++;
      $display("FAIL saturate got stall=%0d flush=%0d want %0d/%0d",
               stall_cnt, flush_cnt, CntMax, CntMax);
    end
  endtask

  task automatic test_random();
    logic [6:0] want;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      id_type     = 2'($urandom_range(0, 3));
      id_rs1      = RegAw'($urandom_range(0, 3));
      id_rs2      = RegAw'($urandom_range(0, 3));
      id_rs2_used = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_rd       = RegAw'($urandom_range(0, 3));
      ex_br_taken = ($urandom_range(0, 9) < 2);
      mem_req     = ($urandom_range(0, 9) < 3);
      mem_ready   = 1'($urandom_range(0, 1));
      #2;
      want = exp_ctrl();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL rand_ctrl n=%0d got=%b want=%b", n, obs, want);
      end
      model_step();
      tick();
      checks++;
      if (stall_cnt !== CntW'(m_stall) || flush_cnt !== CntW'(m_flush)) begin
        failures++;
        $display("FAIL rand_cnt n=%0d got stall=%0d flush=%0d want %0d/%0d",
                 n, stall_cnt, flush_cnt, m_stall, m_flush);
      end
      checks++;
      if (mem_err !== m_err) begin
        failures++;
        $display("FAIL rand_err n=%0d got=%b want=%b", n, mem_err, m_err);
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    test_reset();
    test_reset_mid_wait();
    test_load_use();
    test_no_hazard();
    test_branch_wins();
    test_mem_freeze();
    test_timeout();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
